// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Stall/flush control for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline
//   registers. It handles load-use hazards, taken branches/jumps and
//   I-cache/D-cache waits. A taken branch that resolves during a cache wait
//   is parked in HOLD_BR and applied on the first cycle the caches are ready.
//   It also counts lost-issue cycles, which are cycles with pc_write==0.
// Ports
//   clk, rst          rising-edge clock; synchronous active-low reset
//   id_rs1/2, id_use_rs1/2   source registers of the ID instruction
//   ex_rd, ex_memread        destination and load flag held in ID/EX
//   ex_branch_taken          1-cycle pulse, taken branch/jump resolved in EX
//   im_stall, dm_stall       cache not-ready
//   pc_write .. back_stall   combinational pipeline controls
//   stall_cycles             saturating count of pc_write==0 cycles
//   state                    FSM state (debug)
module hazard_stall_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_branch_taken,
  input  logic              im_stall,
  input  logic              dm_stall,
  output logic              pc_write,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_stall,
  output logic              id_ex_flush,
  output logic              back_stall,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HOLD    = 2'd1,
    HOLD_BR = 2'd2,
    FLUSH   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

  logic busy, lu, br;

  assign busy = im_stall | dm_stall;
  // x0 never carries a real dependency, so a load to x0 cannot cause a bubble.
  assign lu   = ex_memread && (ex_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                 (id_use_rs2 && (id_rs2 == ex_rd)));
  // A parked branch (HOLD_BR) or the trailing FLUSH cycle behaves like a new taken branch.
  assign br   = ex_branch_taken || (state_q == HOLD_BR) || (state_q == FLUSH);

  always_comb begin
    pc_write       = 1'b1;
    if_id_stall    = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_stall    = 1'b0;
    id_ex_flush    = 1'b0;
    back_stall     = 1'b0;
    state_d        = RUN;
    stall_cycles_d = stall_cycles_q;

    if (!rst) begin
      // Reset drives bubbles into the front of the pipe.
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = RUN;
    end else if (busy) begin
      pc_write    = 1'b0;
      if_id_stall = 1'b1;
      id_ex_stall = 1'b1;
      back_stall  = dm_stall;
      state_d     = (ex_branch_taken || (state_q == HOLD_BR)) ? HOLD_BR : HOLD;
    end else if (br) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = (state_q == HOLD_BR) ? FLUSH : RUN;
    end else if (lu) begin
      // The bubble inserted here clears ex_memread on the next cycle, so this lasts one cycle only.
      pc_write    = 1'b0;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end

    if (rst && !pc_write && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= RUN;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign state        = state_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl. Two instances share the stimulus:
// dut is built with CNT_W=32 and dut4 with CNT_W=4, which is used for the saturation check.
module tb_hazard_stall_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_memread, ex_branch_taken, im_stall, dm_stall;

  logic        pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, back_stall;
  logic [31:0] stall_cycles;
  logic [1:0]  state;
  logic        pc_write4, if_id_stall4, if_id_flush4, id_ex_stall4, id_ex_flush4, back_stall4;
  logic [3:0]  stall_cycles4;
  logic [1:0]  state4;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .im_stall(im_stall), .dm_stall(dm_stall), .pc_write(pc_write),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .back_stall(back_stall), .stall_cycles(stall_cycles), .state(state));

  hazard_stall_ctrl #(.REG_AW(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .im_stall(im_stall), .dm_stall(dm_stall), .pc_write(pc_write4),
    .if_id_stall(if_id_stall4), .if_id_flush(if_id_flush4),
    .id_ex_stall(id_ex_stall4), .id_ex_flush(id_ex_flush4),
    .back_stall(back_stall4), .stall_cycles(stall_cycles4), .state(state4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controls packed as {pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, back_stall}
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    #1;
    chk(tag, {26'd0, pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, back_stall},
        {26'd0, exp});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0;
    ex_branch_taken = 1'b0; im_stall = 1'b0; dm_stall = 1'b0;

    // Reset
    @(negedge clk);
    chk_ctl("rst_ctl", 6'b001010);
    tick;
    chk("rst_state", state, 0);
    chk("rst_cnt", stall_cycles, 0);
    rst = 1'b1;
    chk_ctl("idle_ctl", 6'b100000);
    tick;
    chk("idle_cnt", stall_cycles, 0);

    // 1 Load-use
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    chk_ctl("lu_ctl", 6'b010010);
    tick;
    chk("lu_cnt", stall_cycles, 1);
    ex_memread = 1'b0;
    chk_ctl("lu_resume", 6'b100000);
    tick;

    // 2 Load to x0
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
    chk_ctl("x0_ctl", 6'b100000);
    tick;
    chk("x0_cnt", stall_cycles, 1);
    ex_memread = 1'b0; id_use_rs1 = 1'b0;

    // 3 Branch during I-cache wait
    im_stall = 1'b1; ex_branch_taken = 1'b1;
    chk_ctl("brw_c1", 6'b010100);
    tick;
    chk("brw_st1", state, 2);
    ex_branch_taken = 1'b0;
    chk_ctl("brw_c2", 6'b010100);
    tick;
    chk_ctl("brw_c3", 6'b010100);
    tick;
    chk("brw_st3", state, 2);
    chk("brw_cnt", stall_cycles, 4);
    im_stall = 1'b0;
    chk_ctl("brw_apply", 6'b101010);
    tick;
    chk("brw_st_flush", state, 3);
    chk_ctl("brw_flush2", 6'b101010);
    tick;
    chk("brw_st_run", state, 0);
    chk_ctl("brw_normal", 6'b100000);
    chk("brw_cnt2", stall_cycles, 4);

    // 4 D-cache wait for 4 cycles
    dm_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_ctl("dm_ctl", 6'b010101);
      tick;
    end
    chk("dm_cnt", stall_cycles, 8);
    chk("dm_state", state, 1);
    dm_stall = 1'b0;
    chk_ctl("dm_release", 6'b100000);
    tick;
    chk("dm_state_run", state, 0);

    // 5 Load-use and taken branch together: branch wins
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1; ex_branch_taken = 1'b1;
    chk_ctl("lu_br_ctl", 6'b101010);
    tick;
    chk("lu_br_cnt", stall_cycles, 8);
    chk("lu_br_state", state, 0);
    ex_memread = 1'b0; id_use_rs2 = 1'b0; ex_branch_taken = 1'b0;

    // Reset while HOLD_BR discards the pending flush
    im_stall = 1'b1; ex_branch_taken = 1'b1;
    tick;
    chk("hb_state", state, 2);
    ex_branch_taken = 1'b0; rst = 1'b0;
    chk_ctl("hb_rst_ctl", 6'b001010);
    tick;
    chk("hb_rst_state", state, 0);
    rst = 1'b1; im_stall = 1'b0;
    chk_ctl("hb_no_flush", 6'b100000);
    tick;
    chk("hb_cnt", stall_cycles, 0);

    // 6 Saturation with CNT_W=4, then reset
    im_stall = 1'b1;
    repeat (20) tick;
    chk("sat_cnt4", {28'd0, stall_cycles4}, 15);
    chk("sat_cnt32", stall_cycles, 20);
    chk("sat_state", {30'd0, state4}, 1);
    im_stall = 1'b0; rst = 1'b0;
    tick;
    chk("sat_rst_cnt4", {28'd0, stall_cycles4}, 0);
    chk("sat_rst_state4", {30'd0, state4}, 0);
    rst = 1'b1;
    tick;
    chk("post_cnt4", {28'd0, stall_cycles4}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
